grf_wb_arbiter: RTL and testbench
=================================

# grf_wb_arbiter

Write-port arbiter for the single-write-port general register file in the pipelined MIPS core. It shares the register file's one write port between the pipeline's W-stage writeback and a long-latency auxiliary producer (multiply/divide unit, slow load return). Auxiliary writes are buffered in a small in-order queue, and a starvation guard bounds their wait. The block also reports pending queued writes to the hazard unit, so readers stall until the register is committed.

## Interface
Parameters:
- QDEPTH, 2, auxiliary queue depth (entries); legal 2..4
- STARVE_LIMIT, 3, consecutive cycles a non-empty queue head may be denied before it preempts the pipeline

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- wb_we  in  1  pipeline W-stage write request
- wb_addr  in  5  pipeline destination register
- wb_data  in  32  pipeline write data
- wb_pc  in  32  pc of pipeline instruction
- wb_hold  out  1  pipeline write denied this cycle; W stage must hold and re-present next cycle
- aux_valid  in  1  auxiliary write offered
- aux_ready  out  1  queue can accept this cycle
- aux_addr  in  5  auxiliary destination register
- aux_data  in  32  auxiliary write data
- aux_pc  in  32  pc of originating instruction
- rd_a1, rd_a2  in  5 each  register numbers read by the decode stage
- pend_hit1, pend_hit2  out  1 each  matching register has a queued, uncommitted write
- grf_we  out  1  write enable to register file
- grf_a3  out  5  write address to register file
- grf_wd  out  32  write data to register file
- grf_pc  out  32  pc forwarded for register file write trace

## Operation
- Pipeline request: wb_req = wb_we && wb_addr != 0. A pipeline write to $0 is a no-op: no grant, no hold.
- Aux accept: a write is accepted on a posedge where aux_valid && aux_ready. aux_ready = (count < QDEPTH) && !reset; it is independent of same-cycle dequeue. An accepted entry with aux_addr == 0 is consumed and dropped, not enqueued.
- Queue: in-order FIFO of {addr, data, pc}. The head is the oldest entry.
- Starvation counter starve_cnt:
  - Increments each cycle the queue is non-empty and the head is not granted.
  - Clears when the head is granted or the queue is empty.
  - Saturates at STARVE_LIMIT.
- Grant, evaluated each cycle in priority order:
  1. Queue non-empty and (starve_cnt == STARVE_LIMIT or !wb_req): grant head; wb_hold = wb_req.
  2. Else if wb_req: grant pipeline; wb_hold = 0.
  3. Else: grf_we = 0.
- Granted source drives grf_a3, grf_wd and grf_pc. On a head grant, the head is dequeued at the same posedge. When grf_we = 0, grf_a3, grf_wd and grf_pc are 0.
- Enqueue and dequeue may occur on the same edge; count is unchanged.
- pend_hit_n = 1 iff rd_an != 0 and rd_an equals the addr of any valid queue entry. This includes the head being granted this cycle.
- Write ordering to the same register is not reordered or merged. The hazard unit must stall readers and issuers using pend_hit.

## Timing
- grf_we, grf_a3, grf_wd, grf_pc, wb_hold and pend_hit are combinational from the inputs and registered state. The register file samples them at the same posedge.
- Aux latency: accept at edge N; earliest commit at edge N+1, when granted during cycle N..N+1.
- Worst-case head wait under continuous wb_req: STARVE_LIMIT cycles denied, granted in cycle STARVE_LIMIT+1.
- Reset, sampled at posedge:
  - Clears the queue (count = 0) and starve_cnt.
  - While reset is high: grf_we = 0, wb_hold = 0, aux_ready = 0, pend_hit = 0.
- Reset mid-operation discards queued writes; they are never committed.
- Full queue: aux_ready = 0; aux_valid is held by the producer, with no loss.
- Empty queue: starve_cnt = 0 and pend_hit = 0.

## Test plan
- Pipeline only: wb_we=1, addr 5, data 0x1234, for 3 cycles with no aux → grf_we=1 and grf_a3=5 each cycle, wb_hold never asserted, pend_hit=0.
- Aux idle slot: accept aux addr 8, data 0xDEAD at edge N; wb_we=0 → pend_hit1=1 for rd_a1=8 during cycle N..N+1, commit at edge N+1, pend_hit1=0 afterwards.
- Starvation: queue one aux entry (addr 9), then hold wb_req continuously → pipeline granted 3 cycles, then head granted with wb_hold=1 for exactly that cycle, then pipeline resumes.
- Full/backpressure (QDEPTH=2): three aux writes back-to-back under continuous wb_req → aux_ready=0 after the second accept. Third entry accepted on the edge after the first dequeue; commit order matches accept order.
- $0 handling: aux addr 0 accepted → count unchanged, no commit. wb_we=1 with addr 0 → grf_we=0, wb_hold=0. rd_a1=0 → pend_hit1=0.
- Reset mid-operation: two entries queued and starve_cnt=2, assert reset for 1 cycle → no commit, count=0, aux_ready=1 from the first cycle after reset deasserts.

Source files
------------

// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle between the pipeline/aux producer side and the register-file
// write-port arbiter: writeback request, aux queue handshake, hazard lookups, GRF write.
interface grf_wb_arbiter_if;
  // pipeline W-stage writeback
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        wb_hold;

  // auxiliary producer (mul/div, slow load return)
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic [31:0] aux_pc;

  // hazard-unit lookups of pending queued writes
  logic [4:0]  rd_a1;
  logic [4:0]  rd_a2;
  logic        pend_hit1;
  logic        pend_hit2;

  // register file write port
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  // core side: issues requests, observes grants and the GRF write
  modport master (
    output wb_we, wb_addr, wb_data, wb_pc,
    input  wb_hold,
    output aux_valid, aux_addr, aux_data, aux_pc,
    input  aux_ready,
    output rd_a1, rd_a2,
    input  pend_hit1, pend_hit2,
    input  grf_we, grf_a3, grf_wd, grf_pc
  );

  // arbiter side
  modport slave (
    input  wb_we, wb_addr, wb_data, wb_pc,
    output wb_hold,
    input  aux_valid, aux_addr, aux_data, aux_pc,
    output aux_ready,
    input  rd_a1, rd_a2,
    output pend_hit1, pend_hit2,
    output grf_we, grf_a3, grf_wd, grf_pc
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Shares the single GRF write port between pipeline writeback and an in-order
// auxiliary write queue, with a starvation guard and pending-write hazard lookup.
module grf_wb_arbiter #(
  parameter int unsigned QDEPTH       = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic              clk,
  input logic              reset,
  grf_wb_arbiter_if.slave  bus
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wr_entry_t;

  wr_entry_t         q_mem [QDEPTH];
  logic [QDEPTH-1:0] q_valid;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve_cnt;

  wr_entry_t         head_entry;
  logic              wb_req;
  logic              q_nonempty;
  logic              head_grant;
  logic              wb_grant;
  logic              accept;
  logic              enq;
  logic [QDEPTH-1:0] hit1_vec;
  logic [QDEPTH-1:0] hit2_vec;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head_entry = q_mem[head];

  // Arbitration: a starved or uncontested head wins, otherwise the pipeline.
  always_comb begin
    wb_req     = bus.wb_we && (bus.wb_addr != 5'd0);
    q_nonempty = (count != '0);
    head_grant = !reset && q_nonempty &&
                 ((starve_cnt == SW'(STARVE_LIMIT)) || !wb_req);
    wb_grant   = !reset && wb_req && !head_grant;
  end

  // Acceptance ignores a same-cycle dequeue so aux_ready has no path from wb inputs.
  always_comb begin
    bus.aux_ready = (count < CW'(QDEPTH)) && !reset;
    accept        = bus.aux_valid && bus.aux_ready;
    enq           = accept && (bus.aux_addr != 5'd0);
  end

  always_comb begin
    bus.wb_hold = head_grant && wb_req;
    bus.grf_we  = head_grant || wb_grant;
    bus.grf_a3  = 5'd0;
    bus.grf_wd  = 32'd0;
    bus.grf_pc  = 32'd0;
    if (head_grant) begin
      bus.grf_a3 = head_entry.addr;
      bus.grf_wd = head_entry.data;
      bus.grf_pc = head_entry.pc;
    end else if (wb_grant) begin
      bus.grf_a3 = bus.wb_addr;
      bus.grf_wd = bus.wb_data;
      bus.grf_pc = bus.wb_pc;
    end
  end

  // Per-entry address match; the head being committed this cycle still counts.
  for (genvar g = 0; g < QDEPTH; g++) begin : g_hit
    assign hit1_vec[g] = q_valid[g] && (q_mem[g].addr == bus.rd_a1);
    assign hit2_vec[g] = q_valid[g] && (q_mem[g].addr == bus.rd_a2);
  end

  always_comb begin
    bus.pend_hit1 = !reset && (bus.rd_a1 != 5'd0) && (|hit1_vec);
    bus.pend_hit2 = !reset && (bus.rd_a2 != 5'd0) && (|hit2_vec);
  end

  // Payload storage needs no reset; q_valid qualifies every read of it.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      q_mem[tail] <= '{addr: bus.aux_addr, data: bus.aux_data, pc: bus.aux_pc};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      q_valid    <= '0;
      starve_cnt <= '0;
    end else begin
      if (enq) begin
        q_valid[tail] <= 1'b1;
        tail          <= ptr_inc(tail);
      end
      if (head_grant) begin
        q_valid[head] <= 1'b0;
        head          <= ptr_inc(head);
      end

      case ({enq, head_grant})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (!q_nonempty || head_grant) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: expected GRF commits are queued as stimulus
// is driven and popped when the DUT writes; cycle-level outputs checked inline.
module tb_grf_wb_arbiter;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks;
  int   failures;
  exp_t exp_q[$];
  logic [31:0] wd;
  int   aux_n;

  grf_wb_arbiter_if bus ();

  grf_wb_arbiter #(.QDEPTH(2), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    exp_t e;
    e.a = a; e.d = d; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Compare a GRF write against the scoreboard head.
  task automatic commit_mon();
    exp_t e;
    if (bus.grf_we === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_commit observed a3=%0d wd=0x%0h expected no commit",
               bus.grf_a3, bus.grf_wd);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("commit_addr", 64'(bus.grf_a3), 64'(e.a));
        chk("commit_data", 64'(bus.grf_wd), 64'(e.d));
        chk("commit_pc",   64'(bus.grf_pc), 64'(e.pc));
      end
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    commit_mon();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.wb_we = 1'b0;  bus.wb_addr = 5'd0;  bus.wb_data = 32'd0; bus.wb_pc = 32'd0;
    bus.aux_valid = 1'b0; bus.aux_addr = 5'd0; bus.aux_data = 32'd0; bus.aux_pc = 32'd0;
    bus.rd_a1 = 5'd0;  bus.rd_a2 = 5'd0;
  endtask

  task automatic drive_wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_we = 1'b1; bus.wb_addr = a; bus.wb_data = d; bus.wb_pc = d + 32'h1000;
  endtask

  initial begin
    checks = 0; failures = 0; wd = 32'h3000; aux_n = 0;
    clear_inputs();
    reset = 1'b1;

    // reset dominates live requests
    drive_wb(5'd5, 32'h55);
    bus.aux_valid = 1'b1; bus.aux_addr = 5'd7; bus.rd_a1 = 5'd7;
    tick();
    settle();
    chk("reset_grf_we",    64'(bus.grf_we),    64'd0);
    chk("reset_wb_hold",   64'(bus.wb_hold),   64'd0);
    chk("reset_aux_ready", 64'(bus.aux_ready), 64'd0);
    chk("reset_pend_hit1", 64'(bus.pend_hit1), 64'd0);
    tick();
    clear_inputs();
    reset = 1'b0;
    settle();
    chk("post_reset_aux_ready", 64'(bus.aux_ready), 64'd1);
    chk("post_reset_grf_we",    64'(bus.grf_we),    64'd0);
    tick();

    // pipeline only
    for (int k = 0; k < 3; k++) begin
      bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
      bus.wb_pc = 32'h100 + 32'(4 * k); bus.rd_a1 = 5'd5;
      settle();
      chk("pipe_grf_we",  64'(bus.grf_we),    64'd1);
      chk("pipe_grf_a3",  64'(bus.grf_a3),    64'd5);
      chk("pipe_wb_hold", 64'(bus.wb_hold),   64'd0);
      chk("pipe_pend",    64'(bus.pend_hit1), 64'd0);
      push(5'd5, 32'h1234, 32'h100 + 32'(4 * k));
      tick();
    end

    // aux write into an idle slot
    clear_inputs();
    bus.aux_valid = 1'b1; bus.aux_addr = 5'd8; bus.aux_data = 32'hDEAD;
    bus.aux_pc = 32'h200; bus.rd_a1 = 5'd8;
    settle();
    chk("idle_aux_ready", 64'(bus.aux_ready), 64'd1);
    chk("idle_pend_pre",  64'(bus.pend_hit1), 64'd0);
    push(5'd8, 32'hDEAD, 32'h200);
    tick();
    bus.aux_valid = 1'b0;
    settle();
    chk("idle_pend_queued", 64'(bus.pend_hit1), 64'd1);
    chk("idle_commit_we",   64'(bus.grf_we),    64'd1);
    tick();
    settle();
    chk("idle_pend_after", 64'(bus.pend_hit1), 64'd0);
    chk("idle_we_after",   64'(bus.grf_we),    64'd0);

    // starvation: head preempts after 3 denied cycles
    clear_inputs();
    for (int k = 0; k < 6; k++) begin
      drive_wb(5'd3, wd);
      bus.aux_valid = (k == 0);
      bus.aux_addr = 5'd9; bus.aux_data = 32'h9999; bus.aux_pc = 32'h300;
      bus.rd_a2 = 5'd9;
      settle();
      chk("starve_pend2", 64'(bus.pend_hit2), 64'((k >= 1) && (k <= 4)));
      if (k == 4) begin
        chk("starve_hold", 64'(bus.wb_hold), 64'd1);
        chk("starve_a3",   64'(bus.grf_a3),  64'd9);
        push(5'd9, 32'h9999, 32'h300);
      end else begin
        chk("starve_nohold", 64'(bus.wb_hold), 64'd0);
        push(5'd3, wd, wd + 32'h1000);
      end
      tick();
      if (k != 4) wd = wd + 32'd1;
    end

    // full queue backpressure; rd_a1=0 must never hit
    clear_inputs();
    for (int k = 0; k < 14; k++) begin
      drive_wb(5'd4, wd);
      bus.aux_valid = (k <= 5);
      bus.aux_addr  = (k == 0) ? 5'd10 : (k == 1) ? 5'd11 : 5'd12;
      bus.aux_data  = 32'hA000 + 32'(bus.aux_addr);
      bus.aux_pc    = 32'h500 + 32'(bus.aux_addr);
      bus.rd_a1     = 5'd0;
      settle();
      chk("full_pend_r0", 64'(bus.pend_hit1), 64'd0);
      if (k <= 5) chk("full_aux_ready", 64'(bus.aux_ready), 64'((k <= 1) || (k == 5)));
      if (k == 4 || k == 8 || k == 12) begin
        chk("full_hold", 64'(bus.wb_hold), 64'd1);
        push(5'(10 + aux_n), 32'hA000 + 32'(10 + aux_n), 32'h500 + 32'(10 + aux_n));
        aux_n++;
      end else begin
        chk("full_nohold", 64'(bus.wb_hold), 64'd0);
        push(5'd4, wd, wd + 32'h1000);
      end
      tick();
      if (!(k == 4 || k == 8 || k == 12)) wd = wd + 32'd1;
    end

    // $0 handling
    clear_inputs();
    bus.aux_valid = 1'b1; bus.aux_addr = 5'd0; bus.aux_data = 32'hBAD; bus.aux_pc = 32'h600;
    drive_wb(5'd0, 32'h77);
    settle();
    chk("zero_ready",   64'(bus.aux_ready), 64'd1);
    chk("zero_wb_we",   64'(bus.grf_we),    64'd0);
    chk("zero_wb_hold", 64'(bus.wb_hold),   64'd0);
    tick();
    clear_inputs();
    drive_wb(5'd0, 32'h78);
    settle();
    chk("zero_aux_dropped", 64'(bus.grf_we),    64'd0);
    chk("zero_hold2",       64'(bus.wb_hold),   64'd0);
    chk("zero_ready2",      64'(bus.aux_ready), 64'd1);
    tick();

    // reset mid-operation discards two queued entries
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      drive_wb(5'd6, wd);
      bus.aux_valid = (k < 2);
      bus.aux_addr = 5'(20 + k); bus.aux_data = 32'hC000 + 32'(k); bus.aux_pc = 32'h700;
      bus.rd_a1 = 5'd20;
      settle();
      chk("rst_mid_nohold", 64'(bus.wb_hold), 64'd0);
      push(5'd6, wd, wd + 32'h1000);
      tick();
      wd = wd + 32'd1;
    end
    reset = 1'b1;
    settle();
    chk("rst_mid_we",    64'(bus.grf_we),    64'd0);
    chk("rst_mid_hold",  64'(bus.wb_hold),   64'd0);
    chk("rst_mid_ready", 64'(bus.aux_ready), 64'd0);
    chk("rst_mid_pend",  64'(bus.pend_hit1), 64'd0);
    tick();
    reset = 1'b0;
    clear_inputs();
    bus.rd_a1 = 5'd20; bus.rd_a2 = 5'd21;
    settle();
    chk("rst_after_we",    64'(bus.grf_we),    64'd0);
    chk("rst_after_ready", 64'(bus.aux_ready), 64'd1);
    chk("rst_after_pend1", 64'(bus.pend_hit1), 64'd0);
    chk("rst_after_pend2", 64'(bus.pend_hit2), 64'd0);
    tick();
    settle();
    chk("rst_after_we2", 64'(bus.grf_we), 64'd0);
    tick();

    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
